// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: state codes,
// opcode/funct values, datapath select encodings and the Moore output decode.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET_SP  = 5'd0,  S_FETCH   = 5'd1,  S_DECODE   = 5'd2,  S_R_EXEC = 5'd3,
    S_R_WB      = 5'd4,  S_ADDI_EXEC = 5'd5, S_I_WB    = 5'd6,  S_MEM_ADDR = 5'd7,
    S_LW_READ   = 5'd8,  S_LW_WB   = 5'd9,  S_SW_WRITE = 5'd10, S_BEQ    = 5'd11,
    S_J         = 5'd12, S_JAL     = 5'd13, S_JR       = 5'd14, S_EXC    = 5'd15,
    S_BREAK     = 5'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B, OP_BEQ  = 6'h04, OP_J   = 6'h02,
                         OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_JR  = 6'h08, FN_BREAK = 6'h0D;

  localparam logic [1:0] RD_R29 = 2'b00, RD_RT = 2'b01, RD_R31 = 2'b10, RD_RD = 2'b11;
  localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10, M2R_CONST = 2'b11;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [2:0] ALU_IDLE = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010,
                         ALU_AND = 3'b011, ALU_PASSA = 3'b100;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_EXC = 2'b11;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       epc_write;
  } ctrl_t;

  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // last: final cycle of a held FETCH / LW_READ state.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic last,
                                        input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_IDLE;
    case (s)
      S_RESET_SP: begin
        c.reg_dst = RD_R29; c.mem_to_reg = M2R_CONST; c.reg_write = 1'b1;
      end
      S_FETCH: begin
        c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_ADD;
        c.ir_write = last; c.pc_write = last; c.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        c.ab_write = 1'b1; c.alu_out_write = 1'b1;
        c.alu_src_b = SRCB_IMM_SH; c.alu_op = ALU_ADD;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B;
        c.alu_op = funct_alu_op(funct); c.alu_out_write = 1'b1;
      end
      S_R_WB:  begin c.reg_dst = RD_RD; c.mem_to_reg = M2R_ALUOUT; c.reg_write = 1'b1; end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM;
        c.alu_op = ALU_ADD; c.alu_out_write = 1'b1;
      end
      S_I_WB:  begin c.reg_dst = RD_RT; c.mem_to_reg = M2R_ALUOUT; c.reg_write = 1'b1; end
      S_LW_READ: begin c.iord = 1'b1; c.mdr_write = last; end
      S_LW_WB: begin c.reg_dst = RD_RT; c.mem_to_reg = M2R_MDR; c.reg_write = 1'b1; end
      S_SW_WRITE: begin c.iord = 1'b1; c.mem_wr = 1'b1; end
      S_BEQ: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = PCS_ALUOUT;
      end
      S_J:   begin c.pc_write = 1'b1; c.pc_source = PCS_JUMP; end
      // PC already holds PC+4 here, so reg 31 receives the return address.
      S_JAL: begin
        c.reg_dst = RD_R31; c.mem_to_reg = M2R_PC; c.reg_write = 1'b1;
        c.pc_write = 1'b1; c.pc_source = PCS_JUMP;
      end
      S_JR:  begin c.alu_src_a = 1'b1; c.alu_op = ALU_PASSA; c.pc_write = 1'b1; c.pc_source = PCS_ALU; end
      S_EXC: begin
        c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_SUB; c.epc_write = 1'b1;
        c.pc_write = 1'b1; c.pc_source = PCS_EXC;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/datapath bundle: instruction fields and ALU flags in, selects and
// write enables out. master = control unit, slave = datapath side.
interface control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       Overflow;
  logic [1:0] RegDstControl;
  logic [1:0] MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemWR, IRWrite, MDRWrite;
  logic       ABWrite, ALUOutWrite, RegWrite, EPCWrite;
  logic       pc_load;

  // Branch resolution lives on the datapath side of the bundle.
  assign pc_load = PCWrite | (PCWriteCond & Zero);

  modport master (
    input  opcode, funct, Overflow,
    output RegDstControl, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           PCWrite, PCWriteCond, IorD, MemWR, IRWrite, MDRWrite,
           ABWrite, ALUOutWrite, RegWrite, EPCWrite
  );

  modport slave (
    output opcode, funct, Zero, Overflow,
    input  RegDstControl, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           PCWrite, PCWriteCond, IorD, MemWR, IRWrite, MDRWrite,
           ABWrite, ALUOutWrite, RegWrite, EPCWrite, pc_load
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Cycle counter for memory-held states; done marks the last held cycle.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= 3'd0;
    else if (clear)  cnt <= 3'd0;
    else if (enable) cnt <= cnt + 3'd1;
  end

  assign done = enable && (cnt == LAST);
endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM: initialises $sp, fetches, decodes and drives
// every datapath select/enable, with overflow and undefined-op exceptions.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu,
  output logic [4:0]     state_out
);
  state_t state;
  logic   run;
  logic   in_wait;
  logic   last;
  ctrl_t  c;

  assign in_wait = (state == S_FETCH) || (state == S_LW_READ);

  // Held at zero outside wait states, so each FETCH/LW_READ entry starts at 0.
  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (clk),
    .rst    (reset),
    .clear  (!in_wait || last),
    .enable (in_wait),
    .done   (last)
  );

  // run gates outputs off until the first edge after reset release, giving
  // RESET_SP exactly one active cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET_SP;
      run   <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      case (state)
        S_RESET_SP:  state <= S_FETCH;
        S_FETCH:     if (last) state <= S_DECODE;
        S_DECODE: begin
          case (cu.opcode)
            OP_RTYPE: begin
              case (cu.funct)
                FN_ADD, FN_SUB, FN_AND: state <= S_R_EXEC;
                FN_JR:                  state <= S_JR;
                FN_BREAK:               state <= S_BREAK;
                default:                state <= S_EXC;
              endcase
            end
            OP_ADDI:      state <= S_ADDI_EXEC;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BEQ;
            OP_J:         state <= S_J;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_EXC;
          endcase
        end
        S_R_EXEC:    state <= (cu.Overflow && (cu.funct != FN_AND)) ? S_EXC : S_R_WB;
        S_ADDI_EXEC: state <= cu.Overflow ? S_EXC : S_I_WB;
        S_MEM_ADDR:  state <= (cu.opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
        S_LW_READ:   if (last) state <= S_LW_WB;
        S_BREAK:     state <= S_BREAK;
        default:     state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    c = '0;
    if (run) c = ctrl_decode(state, last, cu.funct);
  end

  assign cu.RegDstControl = c.reg_dst;
  assign cu.MemToReg      = c.mem_to_reg;
  assign cu.ALUSrcA       = c.alu_src_a;
  assign cu.ALUSrcB       = c.alu_src_b;
  assign cu.ALUOp         = c.alu_op;
  assign cu.PCSource      = c.pc_source;
  assign cu.PCWrite       = c.pc_write;
  assign cu.PCWriteCond   = c.pc_write_cond;
  assign cu.IorD          = c.iord;
  assign cu.MemWR         = c.mem_wr;
  assign cu.IRWrite       = c.ir_write;
  assign cu.MDRWrite      = c.mdr_write;
  assign cu.ABWrite       = c.ab_write;
  assign cu.ALUOutWrite   = c.alu_out_write;
  assign cu.RegWrite      = c.reg_write;
  assign cu.EPCWrite      = c.epc_write;
  assign state_out        = state;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction signature table with a scoreboard,
// plus reset, break and reset-during-load sequences.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int MW = 3;

  typedef struct packed {
    logic [4:0] lat;
    logic [2:0] xop;
    logic       xsa;
    logic [1:0] xsb;
    logic       rw;
    logic [1:0] dst;
    logic [1:0] m2r;
    logic       epc;
    logic       mw;
    logic       mdr;
    logic       iord;
    logic       pcw;
    logic [1:0] pcs;
    logic       pcwc;
  } sig_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       ovf;
    sig_t       exp;
    string      name;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  state_out;
  logic [21:0] all_out;
  logic [23:0] exp_q[$];
  int          total;
  int          bad;
  vec_t        vecs[15];

  control_unit_if cu();

  control_unit #(.MEM_WAIT(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cu        (cu),
    .state_out (state_out)
  );

  assign all_out = {cu.RegDstControl, cu.MemToReg, cu.ALUSrcA, cu.ALUSrcB, cu.ALUOp,
                    cu.PCSource, cu.PCWrite, cu.PCWriteCond, cu.IorD, cu.MemWR,
                    cu.IRWrite, cu.MDRWrite, cu.ABWrite, cu.ALUOutWrite,
                    cu.RegWrite, cu.EPCWrite};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic sig_t mk(input int lat, input logic [2:0] xop, input logic xsa,
                              input logic [1:0] xsb, input logic rw, input logic [1:0] dst,
                              input logic [1:0] m2r, input logic epc, input logic mw,
                              input logic mdr, input logic iord, input logic pcw,
                              input logic [1:0] pcs, input logic pcwc);
    sig_t s;
    s.lat = 5'(lat); s.xop = xop; s.xsa = xsa; s.xsb = xsb; s.rw = rw; s.dst = dst;
    s.m2r = m2r; s.epc = epc; s.mw = mw; s.mdr = mdr; s.iord = iord; s.pcw = pcw;
    s.pcs = pcs; s.pcwc = pcwc;
    return s;
  endfunction

  // driver tasks
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    cu.opcode   = op;
    cu.funct    = fn;
    cu.Overflow = ovf;
    cu.Zero     = 1'($urandom_range(0, 1));
  endtask

  // Leaves the bench at a negedge in the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hold", {state_out, all_out}, {S_RESET_SP, 22'd0});
    reset = 1'b0;
    @(negedge clk);
    check("reset_sp", {state_out, all_out},
          {S_RESET_SP, 2'b00, 2'b11, 1'b0, 2'b00, 3'b000, 2'b00, 8'd0, 1'b1, 1'b0});
    @(negedge clk);
  endtask

  task automatic run_instr(input vec_t v);
    sig_t obs;
    sig_t got;
    int   cyc;
    int   lwc;
    bit   left;
    bit   fin;
    obs = '0; cyc = 0; lwc = 0; left = 0; fin = 0;
    drive(v.op, v.fn, v.ovf);
    exp_q.push_back(v.exp);
    while (!fin && cyc < 40) begin
      if (cyc < MW)
        check({v.name, "/fetch"},
              {state_out, cu.IorD, cu.ALUSrcA, cu.ALUSrcB, cu.ALUOp, cu.IRWrite,
               cu.PCWrite, cu.PCSource, cu.RegWrite, cu.MemWR},
              {S_FETCH, 1'b0, 1'b0, 2'b01, 3'b001, (cyc == MW - 1), (cyc == MW - 1),
               2'b00, 1'b0, 1'b0});
      else if (cyc == MW)
        check({v.name, "/decode"},
              {state_out, cu.ABWrite, cu.ALUOutWrite, cu.ALUSrcA, cu.ALUSrcB, cu.ALUOp,
               cu.RegWrite, cu.PCWrite, cu.PCWriteCond, cu.MemWR},
              {S_DECODE, 1'b1, 1'b1, 1'b0, 2'b11, 3'b001, 4'b0000});
      if (state_out == S_LW_READ) begin
        check({v.name, "/mdr"}, {cu.IorD, cu.MDRWrite}, {1'b1, (lwc == MW - 1)});
        lwc++;
      end
      if (cyc == MW + 1) begin
        obs.xop = cu.ALUOp; obs.xsa = cu.ALUSrcA; obs.xsb = cu.ALUSrcB;
      end
      if (cyc >= MW) begin
        if (cu.RegWrite) begin
          obs.rw = 1'b1; obs.dst = cu.RegDstControl; obs.m2r = cu.MemToReg;
        end
        obs.epc  |= cu.EPCWrite;
        obs.mw   |= cu.MemWR;
        obs.mdr  |= cu.MDRWrite;
        obs.iord |= cu.IorD;
        obs.pcw  |= cu.PCWrite;
        obs.pcwc |= cu.PCWriteCond;
        if (cu.PCWrite || cu.PCWriteCond) obs.pcs = cu.PCSource;
      end
      @(negedge clk);
      cyc++;
      if (state_out != S_FETCH) left = 1;
      else if (left) fin = 1;
    end
    obs.lat = 5'(cyc);
    got = exp_q.pop_front();
    check(v.name, obs, got);
    if (!fin) begin
      total++; bad++;
      $display("FAIL %s/timeout: got no return to fetch want fetch within 40", v.name);
      do_reset();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    drive(6'h00, 6'h20, 1'b0);

    // op, funct, ovf, {lat, xop, xsa, xsb, rw, dst, m2r, epc, mw, mdr, iord, pcw, pcs, pcwc}
    vecs[0]  = '{6'h00, 6'h20, 1'b0, mk(MW+3,   3'b001, 1, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0), "add"};
    vecs[1]  = '{6'h00, 6'h22, 1'b1, mk(MW+3,   3'b010, 1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b11, 0), "sub_ovf"};
    vecs[2]  = '{6'h00, 6'h24, 1'b1, mk(MW+3,   3'b011, 1, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0), "and_ovf"};
    vecs[3]  = '{6'h00, 6'h22, 1'b0, mk(MW+3,   3'b010, 1, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0), "sub"};
    vecs[4]  = '{6'h08, 6'h15, 1'b0, mk(MW+3,   3'b001, 1, 2'b10, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0), "addi"};
    vecs[5]  = '{6'h08, 6'h15, 1'b1, mk(MW+3,   3'b001, 1, 2'b10, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b11, 0), "addi_ovf"};
    vecs[6]  = '{6'h23, 6'h00, 1'b1, mk(2*MW+3, 3'b001, 1, 2'b10, 1, 2'b01, 2'b01, 0, 0, 1, 1, 0, 2'b00, 0), "lw"};
    vecs[7]  = '{6'h2B, 6'h00, 1'b1, mk(MW+3,   3'b001, 1, 2'b10, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0), "sw"};
    vecs[8]  = '{6'h04, 6'h00, 1'b0, mk(MW+2,   3'b010, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1), "beq"};
    vecs[9]  = '{6'h02, 6'h00, 1'b0, mk(MW+2,   3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0), "j"};
    vecs[10] = '{6'h03, 6'h00, 1'b0, mk(MW+2,   3'b000, 0, 2'b00, 1, 2'b10, 2'b10, 0, 0, 0, 0, 1, 2'b10, 0), "jal"};
    vecs[11] = '{6'h00, 6'h08, 1'b1, mk(MW+2,   3'b100, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0), "jr"};
    vecs[12] = '{6'h3F, 6'h00, 1'b0, mk(MW+2,   3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b11, 0), "undef_op"};
    vecs[13] = '{6'h00, 6'h21, 1'b0, mk(MW+2,   3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b11, 0), "undef_fn"};
    vecs[14] = '{6'h00, 6'h20, 1'b1, mk(MW+3,   3'b001, 1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b11, 0), "add_ovf"};

    do_reset();
    for (int i = 0; i < 15; i++) run_instr(vecs[i]);
    for (int i = 0; i < 12; i++) run_instr(vecs[$urandom_range(0, 14)]);

    // break: machine parks with every output low
    drive(6'h00, 6'h0D, 1'b0);
    repeat (MW + 1) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("break_idle", {state_out, all_out}, {S_BREAK, 22'd0});
      @(negedge clk);
    end
    do_reset();

    // reset in the second LW_READ cycle aborts before MDRWrite
    drive(6'h23, 6'h00, 1'b0);
    repeat (MW + 3) @(negedge clk);
    check("lw_read2", {state_out, cu.IorD, cu.MDRWrite}, {S_LW_READ, 1'b1, 1'b0});
    #2 reset = 1'b1;
    #1 check("lw_abort", {state_out, all_out}, {S_RESET_SP, 22'd0});
    do_reset();
    run_instr(vecs[6]);
    run_instr(vecs[0]);

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle Moore control FSM for the MIPS-subset datapath. Decodes opcode/funct from the instruction register and drives every datapath select and write enable, including the 2-bit write-register select consumed by the RegDst mux. Sits upstream of RegDst, the register bank, ALU, PC/EPC registers and memory. It also initialises `$sp` (reg 29) after reset and handles overflow and undefined-instruction exceptions.

## Interface
- MEM_WAIT, 2: memory read latency in cycles (1..7); fetch and load-read states are held this long.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- Overflow  in  1  ALU signed-overflow flag (combinational, same cycle).
- RegDstControl  out  2  00=reg 29, 01=rt, 10=reg 31, 11=rd.
- MemToReg  out  2  00=ALUOut, 01=MDR, 10=PC, 11=constant 227.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=const 4, 10=signext(imm), 11=signext(imm)<<2.
- ALUOp  out  3  001 add, 010 sub, 011 and, 100 pass A, 000 idle.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector 255.
- PCWrite, PCWriteCond, IorD, MemWR, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite, EPCWrite  out  1 each.
- state_out  out  5  current state code (debug).

## Operation
- Moore machine: outputs are a pure function of state and the wait counter. Any signal not listed for a state is 0.
- RESET_SP: RegDstControl=00, MemToReg=11, RegWrite. -> FETCH.
- FETCH: held MEM_WAIT cycles. IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp add. Last cycle adds IRWrite, PCWrite, PCSource=00. -> DECODE.
- DECODE: ABWrite, ALUOutWrite, ALUSrcA=0, ALUSrcB=11, ALUOp add. Dispatch on opcode:
  - 0x00: by funct — 0x20/0x22/0x24 -> R_EXEC, 0x08 -> JR, 0x0D -> BREAK.
  - 0x08 -> ADDI_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04 -> BEQ; 0x02 -> J; 0x03 -> JAL.
  - Anything else -> EXC.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from funct, ALUOutWrite. Overflow and funct is add/sub -> EXC, else -> R_WB.
- R_WB: RegDstControl=11, MemToReg=00, RegWrite. -> FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, add, ALUOutWrite. Overflow -> EXC, else -> I_WB.
- I_WB: RegDstControl=01, MemToReg=00, RegWrite. -> FETCH.
- MEM_ADDR: as ADDI_EXEC without the overflow check. lw -> LW_READ; sw -> SW_WRITE.
- LW_READ: IorD=1, held MEM_WAIT cycles; MDRWrite on last cycle. -> LW_WB.
- LW_WB: RegDstControl=01, MemToReg=01, RegWrite. -> FETCH.
- SW_WRITE: IorD=1, MemWR. -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01. -> FETCH.
- J: PCWrite, PCSource=10. -> FETCH.
- JAL: RegDstControl=10, MemToReg=10, RegWrite, PCWrite, PCSource=10. -> FETCH. The PC is already PC+4 here, so reg 31 receives the return address.
- JR: ALUSrcA=1, ALUOp pass A, PCWrite, PCSource=00. -> FETCH.
- EXC: ALUSrcA=0, ALUSrcB=01, sub, EPCWrite (EPC <- PC-4), PCWrite, PCSource=11. -> FETCH.
- BREAK: all outputs 0; stays in BREAK until reset.

## Timing
- While reset is asserted: state=RESET_SP, wait counter=0, every output 0 except state_out.
- Reset asserted mid-operation aborts immediately, including mid-wait; no partial write is completed.
- First rising edge after reset deasserts: RESET_SP outputs are active for exactly one cycle.
- Wait counter (3 bits):
  - Cleared on entry to FETCH or LW_READ.
  - Increments each cycle in those states.
  - The state's last cycle is counter==MEM_WAIT-1.
  - With MEM_WAIT=1 these states last one cycle.
- Instruction latency in cycles, W=MEM_WAIT:
  - R-type: W+3.
  - addi: W+3.
  - lw: 2W+3.
  - sw: W+3.
  - beq, j, jal, jr: W+2.
  - Overflow path: W+3.
- Overflow is sampled only on the final edge of R_EXEC/ADDI_EXEC. It is ignored for the and instruction and for MEM_ADDR.
- PCWriteCond and Zero are combined outside this block: PC is loaded when PCWrite | (PCWriteCond & Zero).

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - state encoding (5-bit localparams);
  - opcode/funct constants;
  - RegDstControl, MemToReg, ALUSrcB, PCSource and ALUOp encodings.
- The RegDst mux, MemToReg mux and ALU import the same package.
- One sub-module, `mem_wait_counter`: clear, enable, MEM_WAIT parameter, `done` output. Both FETCH and LW_READ use it.

## Test plan
- Reset release, MEM_WAIT=2 -> one cycle RegDstControl=00, MemToReg=11, RegWrite=1; then FETCH with IRWrite and PCWrite on its 2nd cycle.
- add (op 0x00, funct 0x20), Overflow=0 -> R_WB asserts RegDstControl=11, RegWrite=1; total 5 cycles FETCH-to-FETCH.
- addi with Overflow=1 in ADDI_EXEC -> EXC: EPCWrite=1, PCSource=11, PCWrite=1; RegWrite never asserted.
- lw with MEM_WAIT=3 -> LW_READ lasts 3 cycles, MDRWrite only on the 3rd; LW_WB has RegDstControl=01, MemToReg=01; total 9 cycles.
- jal -> one cycle with RegDstControl=10, MemToReg=10, RegWrite=1, PCWrite=1, PCSource=10.
- opcode 0x3F -> EXC. break -> BREAK, outputs 0 for 20 cycles. Reset asserted in the 2nd LW_READ cycle -> immediately RESET_SP, no MDRWrite.
